// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - shared constants and FSM encoding for mult_arbiter
// Purpose: default sizing and the arbiter state encoding, imported by every
// file of the block.
package mult_arbiter_pkg;

  localparam int DEF_N           = 4;
  localparam int DEF_W           = 8;
  localparam int DEF_ACK_TIMEOUT = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/mult.sv
// rtl/mult.sv - iterative shift-add unsigned multiplier with start/busy handshake
// Purpose: W x W -> 2W unsigned product, one multiplier bit per cycle.
// busy_o rises the cycle after start_i and stays high for W cycles; y_bo is
// the final product once busy_o falls. start_i is ignored while busy.
// Ports:
//   clk_i, rst_i (async, active-high), start_i, a_bi/b_bi operands,
//   busy_o, y_bo product.
module mult
  import mult_arbiter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  output logic           busy_o,
  output logic [2*W-1:0] y_bo
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else if (busy_o) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) busy_o <= 1'b0;
    end else if (start_i) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a_bi};
      mplier <= b_bi;
      cnt    <= CW'(W);
      busy_o <= 1'b1;
    end
  end

  assign y_bo = acc;

endmodule

// File: rtl/mult_arbiter_rr_pick.sv
// rtl/mult_arbiter_rr_pick.sv - combinational round-robin requester picker
// Purpose: find the first set request bit scanning upward from ptr+1, wrapping
// modulo N, so the requester at ptr gets lowest priority.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  last served index
//   any  out 1   at least one request present
//   idx  out IW  chosen requester (0 when any is low)
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int k;

  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one iterative multiplier
// Purpose: grants one of N requesters, latches its operands, runs the
// multiplier start/busy handshake and returns the product with a one-cycle
// done pulse. A multiplier that never raises busy is reported via err_o.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   req_bi/a_bi/b_bi      per-requester request and packed operands
//   gnt_bo/done_bo/err_o  owner one-hot, completion pulse, no-ack error pulse
//   y_bo/busy_o           held product, transaction in flight
//   mul_*                 interface to the external multiplier
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int W           = DEF_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_bi,
  input  logic [N*W-1:0] a_bi,
  input  logic [N*W-1:0] b_bi,
  output logic [N-1:0]   gnt_bo,
  output logic [N-1:0]   done_bo,
  output logic           err_o,
  output logic [2*W-1:0] y_bo,
  output logic           busy_o,
  output logic [W-1:0]   mul_a_bo,
  output logic [W-1:0]   mul_b_bo,
  output logic           mul_start_o,
  input  logic           mul_busy_i,
  input  logic [2*W-1:0] mul_y_bi
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n, rr_ptr, ptr_n, pick_idx;
  logic [N-1:0]   gnt_n;
  logic [2*W-1:0] y_n;
  logic [W-1:0]   a_n, b_n;
  logic [CW-1:0]  ack_cnt, cnt_n;
  logic           err_flag, err_n, pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req_bi),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      idx      <= '0;
      rr_ptr   <= IW'(N - 1);
      gnt_bo   <= '0;
      y_bo     <= '0;
      mul_a_bo <= '0;
      mul_b_bo <= '0;
      ack_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      rr_ptr   <= ptr_n;
      gnt_bo   <= gnt_n;
      y_bo     <= y_n;
      mul_a_bo <= a_n;
      mul_b_bo <= b_n;
      ack_cnt  <= cnt_n;
      err_flag <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ptr_n   = rr_ptr;
    gnt_n   = gnt_bo;
    y_n     = y_bo;
    a_n     = mul_a_bo;
    b_n     = mul_b_bo;
    cnt_n   = ack_cnt;
    err_n   = err_flag;
    case (state)
      S_IDLE: begin
        if (pick_any) begin
          idx_n           = pick_idx;
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          a_n             = a_bi[int'(pick_idx) * W +: W];
          b_n             = b_bi[int'(pick_idx) * W +: W];
          err_n           = 1'b0;
          state_n         = S_START;
        end
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (mul_busy_i) begin
          state_n = S_WAIT_DONE;
        end else begin
          cnt_n = ack_cnt + 1'b1;
          // No acknowledge: finish with error and a zero product.
          if (cnt_n == CW'(ACK_TIMEOUT)) begin
            err_n   = 1'b1;
            y_n     = '0;
            state_n = S_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!mul_busy_i) begin
          y_n     = mul_y_bi;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        ptr_n   = idx;
        gnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pulses decode directly from the registered state so each lasts one cycle.
  always_comb begin
    done_bo = '0;
    if (state == S_DONE) done_bo[idx] = 1'b1;
  end

  assign err_o       = (state == S_DONE) && err_flag;
  assign mul_start_o = (state == S_START);
  assign busy_o      = (state != S_IDLE);

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one iterative `mult` instance (8x8 -> 16 unsigned, start/busy handshake) between N requesters.
- Picks a requester by round-robin and latches its operands.
- Sequences the multiplier's start/busy handshake, then returns the product with a one-cycle done pulse to the owning requester.
- Sits between client blocks and the multiplier. `mult` is instantiated beside it, not inside it.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand width; product width is 2*W.
- ACK_TIMEOUT, 4, max cycles to wait for mul_busy_i to rise after a start pulse.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_bi  in  N  per-requester level request; held high until that requester's done_bo bit pulses.
- a_bi  in  N*W  operand A, requester k at bits [k*W +: W].
- b_bi  in  N*W  operand B, same packing.
- gnt_bo  out  N  one-hot current owner; 0 when idle.
- done_bo  out  N  one-cycle completion pulse to the owner.
- err_o  out  1  one-cycle pulse with done_bo when the multiplier never acknowledged.
- y_bo  out  2*W  product; valid with done_bo, held until the next completion.
- busy_o  out  1  transaction in flight (any state except IDLE).
- mul_a_bo  out  W  operand A to mult.
- mul_b_bo  out  W  operand B to mult.
- mul_start_o  out  1  start pulse to mult.
- mul_busy_i  in  1  mult busy.
- mul_y_bi  in  2*W  mult result.

Behaviour:
- Reset (async, any state) drives all of the following to 0 and the state to IDLE:
  - gnt_bo, done_bo, err_o, y_bo, busy_o, mul_a_bo, mul_b_bo, mul_start_o, idx, ack counter.
  - rr_ptr is reset to N-1, so requester 0 has first priority.
- States and transitions, all registered:
  - IDLE: if req_bi != 0, pick the first set bit scanning from rr_ptr+1 upward modulo N. Latch idx, gnt_bo=1<<idx, and operands into mul_a_bo/mul_b_bo. Go to START. If req_bi == 0, stay.
  - START: mul_start_o=1 for exactly this cycle; clear the ack counter; go to WAIT_ACK.
  - WAIT_ACK: if mul_busy_i=1, go to WAIT_DONE. Otherwise increment the counter; when it reaches ACK_TIMEOUT, go to DONE with the error flag set.
  - WAIT_DONE: stay while mul_busy_i=1. On mul_busy_i=0, capture y_bo<=mul_y_bi and go to DONE.
  - DONE: done_bo[idx]=1 for one cycle, plus err_o=1 if the error flag is set (y_bo=0 in that case). rr_ptr<=idx; gnt_bo<=0; go to IDLE.
- Operand latching and stability:
  - mul_a_bo/mul_b_bo are latched in IDLE and held from START through DONE.
  - Requester operand changes after the grant are ignored.
- Latency:
  - req seen in IDLE at cycle 0: start at cycle 1; done pulse at 1 cycle after mul_busy_i is observed low.
  - Arbiter overhead is 3 cycles on top of the multiplier busy time.
  - Back-to-back grants have at least one IDLE cycle between them.
- Requester obligations:
  - The requester drops req the cycle after its done pulse.
  - A req still high in IDLE counts as a new request; round-robin places that requester last.
- Simultaneous requests: exactly one grant per transaction. With all N requesting continuously, grant order is 0,1,2,...,N-1,0,...
- Non-owner requests are not affected while a transaction is in flight: pending reqs are only sampled in IDLE.
- Reset mid-transaction:
  - Immediate return to IDLE, with no done pulse and y_bo=0.
  - The multiplier shares rst_i, so it is reset too.
- Width rules: product is unsigned 2*W. No truncation or saturation; 255*255=65025 fits in 16 bits.

Decomposition:
- Shared constants header holds:
  - State encodings IDLE/START/WAIT_ACK/WAIT_DONE/DONE (3 bits).
  - Default W and N.
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: req [N], ptr [clog2 N].
  - Outputs: any, idx [clog2 N].
- Bench top instantiates mult_arbiter + mult together.

Test Plan:
- Single requester 2, a=16 b=117 -> one done_bo=4'b0100 pulse, y_bo=1872, err_o=0, busy_o low after DONE.
- Requester 0, a=255 b=255, then a=0 b=1 -> y_bo=65025, then y_bo=0; two separate done pulses, gnt_bo=0001 both times.
- Requesters 0,1,3 raise req in the same cycle with distinct operands (3*5, 7*9, 200*2) -> completions in order 0,1,3 with y_bo=15, 63, 400; gnt_bo always one-hot.
- All four requesters held high for 8 transactions -> grant sequence 0,1,2,3,0,1,2,3; one IDLE cycle between grants.
- Assert rst_i during WAIT_DONE -> same-cycle async return: gnt_bo=0, busy_o=0, y_bo=0, no done pulse. A new request after release completes correctly (16*117=1872).
- Stub multiplier that never raises busy -> after start, ACK_TIMEOUT cycles in WAIT_ACK, then done_bo + err_o pulse together with y_bo=0, and the next requester is served normally.
